// File: rtl/rcv_pkg.sv
// Shared types and helpers for the serial receive sequencer.
package rcv_pkg;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 200;
    localparam int unsigned DEF_CNT_BITS       = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        RECEIVE   = 3'd2,
        STOP_CHK  = 3'd3,
        STOP_WAIT = 3'd4,
        LOAD      = 3'd5,
        ERR       = 3'd6
    } state_e;

    // Increment that sticks at the all-ones value of a 'bits'-wide counter.
    function automatic int unsigned sat_inc(input int unsigned val, input int unsigned bits);
        int unsigned max_val;
        max_val = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        return (val >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Terminal-count counter: counts while enabled, wraps to 1 after rollover_val,
// flags when the count sits at rollover_val.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count_q == rollover_val) ? NUM_CNT_BITS'(1)
                                                : count_q + NUM_CNT_BITS'(1);
        end
        flag_d = !clear && (count_d == rollover_val);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign rollover_flag = flag_q;

endmodule

// File: rtl/rcv_sequencer.sv
// Receive-side controller: frame sequencing, stop-bit check, buffer load,
// consumer handshake, error flags, status counters and receive watchdog.
module rcv_sequencer
    import rcv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_BITS       = DEF_CNT_BITS
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start_bit_detected,
    input  logic                byte_received,
    input  logic                stop_bit,
    input  logic                data_read,
    output logic                rcving,
    output logic                sbc_clear,
    output logic                sbc_enable,
    output logic                load_buffer,
    output logic                data_ready,
    output logic                overrun_error,
    output logic                framing_error,
    output logic [CNT_BITS-1:0] good_count,
    output logic [CNT_BITS-1:0] err_count
);

    localparam int unsigned WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state_q, state_d;
    logic                rcving_q, rcving_d;
    logic                sbc_clear_q, sbc_clear_d;
    logic                sbc_enable_q, sbc_enable_d;
    logic                load_buffer_q, load_buffer_d;
    logic                data_ready_q, data_ready_d;
    logic                overrun_q, overrun_d;
    logic                framing_q, framing_d;
    logic [CNT_BITS-1:0] good_q, good_d;
    logic [CNT_BITS-1:0] err_q, err_d;
    logic                wd_timeout;

    flex_counter #(.NUM_CNT_BITS(WD_BITS)) u_watchdog (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (state_q == START),
        .count_enable (state_q == RECEIVE),
        .rollover_val (WD_BITS'(TIMEOUT_CYCLES - 1)),
        .rollover_flag(wd_timeout)
    );

    always_comb begin
        state_d      = state_q;
        data_ready_d = data_ready_q;
        overrun_d    = overrun_q;
        framing_d    = framing_q;
        good_d       = good_q;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (start_bit_detected) begin
                    state_d   = START;
                    framing_d = 1'b0;
                end
            end
            START:    state_d = RECEIVE;
            RECEIVE: begin
                if (byte_received) begin
                    state_d = STOP_CHK;
                end else if (wd_timeout) begin
                    state_d = ERR;
                end
            end
            STOP_CHK:  state_d = STOP_WAIT;
            STOP_WAIT: state_d = stop_bit ? LOAD : ERR;
            LOAD: begin
                state_d = IDLE;
                good_d  = CNT_BITS'(sat_inc(32'(good_q), CNT_BITS));
            end
            ERR: begin
                state_d   = IDLE;
                framing_d = 1'b1;
                err_d     = CNT_BITS'(sat_inc(32'(err_q), CNT_BITS));
            end
            default: state_d = IDLE;
        endcase

        // A load always wins over a simultaneous acknowledge.
        if (state_q == LOAD) begin
            data_ready_d = 1'b1;
            if (data_ready_q && !data_read) begin
                overrun_d = 1'b1;
            end
        end else if (data_read && data_ready_q) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end

        // Strobes are registered from the next state so they track state_q exactly.
        rcving_d      = (state_d == START) || (state_d == RECEIVE);
        sbc_clear_d   = (state_d == START);
        sbc_enable_d  = (state_d == STOP_CHK);
        load_buffer_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            rcving_q      <= 1'b0;
            sbc_clear_q   <= 1'b0;
            sbc_enable_q  <= 1'b0;
            load_buffer_q <= 1'b0;
            data_ready_q  <= 1'b0;
            overrun_q     <= 1'b0;
            framing_q     <= 1'b0;
            good_q        <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            rcving_q      <= rcving_d;
            sbc_clear_q   <= sbc_clear_d;
            sbc_enable_q  <= sbc_enable_d;
            load_buffer_q <= load_buffer_d;
            data_ready_q  <= data_ready_d;
            overrun_q     <= overrun_d;
            framing_q     <= framing_d;
            good_q        <= good_d;
            err_q         <= err_d;
        end
    end

    assign rcving        = rcving_q;
    assign sbc_clear     = sbc_clear_q;
    assign sbc_enable    = sbc_enable_q;
    assign load_buffer   = load_buffer_q;
    assign data_ready    = data_ready_q;
    assign overrun_error = overrun_q;
    assign framing_error = framing_q;
    assign good_count    = good_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_rcv_sequencer.sv
// Scoreboard bench for rcv_sequencer: stimulus queues expected strobes and
// status snapshots, a monitor pops and compares them at the falling edge.
module tb_rcv_sequencer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start_bit_detected = 1'b0;
    logic       byte_received = 1'b0;
    logic       stop_bit = 1'b0;
    logic       data_read = 1'b0;
    logic       rcving, sbc_clear, sbc_enable, load_buffer;
    logic       data_ready, overrun_error, framing_error;
    logic [7:0] good_count, err_count;

    always #5 clk = ~clk;

    rcv_sequencer #(.TIMEOUT_CYCLES(200), .CNT_BITS(8)) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .start_bit_detected(start_bit_detected),
        .byte_received     (byte_received),
        .stop_bit          (stop_bit),
        .data_read         (data_read),
        .rcving            (rcving),
        .sbc_clear         (sbc_clear),
        .sbc_enable        (sbc_enable),
        .load_buffer       (load_buffer),
        .data_ready        (data_ready),
        .overrun_error     (overrun_error),
        .framing_error     (framing_error),
        .good_count        (good_count),
        .err_count         (err_count)
    );

    typedef struct {
        bit         is_status;
        string      name;
        logic [2:0] strb;
        logic       rcv;
        logic       dr;
        logic       ov;
        logic       fe;
        logic [7:0] gc;
        logic [7:0] ec;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   snap_req = 1'b0;

    // Reference view of the sticky status, updated per the handshake rules.
    logic m_dr = 1'b0, m_ov = 1'b0, m_fe = 1'b0;
    int   m_gc = 0, m_ec = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_strb(input string nm, input logic [2:0] s, input logic r);
        exp_t e;
        e.is_status = 1'b0; e.name = nm; e.strb = s; e.rcv = r;
        e.dr = 1'b0; e.ov = 1'b0; e.fe = 1'b0; e.gc = 8'd0; e.ec = 8'd0;
        q.push_back(e);
    endtask

    task automatic snap(input string nm, input logic r);
        exp_t e;
        e.is_status = 1'b1; e.name = nm; e.strb = 3'b000; e.rcv = r;
        e.dr = m_dr; e.ov = m_ov; e.fe = m_fe; e.gc = 8'(m_gc); e.ec = 8'(m_ec);
        q.push_back(e);
        snap_req = 1'b1;
        @(negedge clk);
        #1;
        snap_req = 1'b0;
    endtask

    function automatic int sat8(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic read_pulse();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        if (m_dr) begin
            m_dr = 1'b0;
            m_ov = 1'b0;
        end
    endtask

    // wait_cyc: RECEIVE cycles before byte_received is presented (>= 1).
    task automatic frame(input bit stop, input bit rd_in_load, input int wait_cyc, input bit chk_edges);
        push_strb("sbc_clear", 3'b100, 1'b1);
        stop_bit = stop;
        start_bit_detected = 1'b1;
        tick();
        start_bit_detected = 1'b0;
        m_fe = 1'b0;
        if (chk_edges) snap("start_cycle", 1'b1);
        repeat (wait_cyc) tick();
        push_strb("sbc_enable", 3'b010, 1'b0);
        byte_received = 1'b1;
        tick();
        byte_received = 1'b0;
        tick();
        if (stop) push_strb("load_buffer", 3'b001, 1'b0);
        tick();
        if (rd_in_load) data_read = 1'b1;
        if (chk_edges && stop) snap("load_cycle", 1'b0);
        tick();
        data_read = 1'b0;
        if (stop) begin
            if (m_dr && !rd_in_load) m_ov = 1'b1;
            m_dr = 1'b1;
            m_gc = sat8(m_gc);
        end else begin
            if (rd_in_load && m_dr) begin
                m_dr = 1'b0;
                m_ov = 1'b0;
            end
            m_fe = 1'b1;
            m_ec = sat8(m_ec);
        end
        snap("frame_end", 1'b0);
    endtask

    task automatic timeout_frame();
        push_strb("sbc_clear", 3'b100, 1'b1);
        start_bit_detected = 1'b1;
        tick();
        start_bit_detected = 1'b0;
        m_fe = 1'b0;
        repeat (200) tick();
        snap("receive_cycle_200", 1'b1);
        tick();
        snap("err_cycle", 1'b0);
        tick();
        m_fe = 1'b1;
        m_ec = sat8(m_ec);
        snap("timeout_end", 1'b0);
    endtask

    task automatic reset_mid_frame();
        push_strb("sbc_clear", 3'b100, 1'b1);
        start_bit_detected = 1'b1;
        tick();
        start_bit_detected = 1'b0;
        repeat (10) tick();
        n_rst = 1'b0;
        m_dr = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_gc = 0; m_ec = 0;
        snap("reset_mid_frame", 1'b0);
        repeat (2) tick();
        n_rst = 1'b1;
        repeat (3) tick();
        snap("after_reset", 1'b0);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [2:0] strb;
        forever begin
            @(negedge clk);
            strb = {sbc_clear, sbc_enable, load_buffer};
            if (strb != 3'b000) begin
                checks++;
                if (q.size() == 0 || q[0].is_status) begin
                    errors++;
                    $display("FAIL unexpected_strobe got clr/en/load=%b rcving=%b, none expected", strb, rcving);
                end else begin
                    e = q.pop_front();
                    if (strb !== e.strb || rcving !== e.rcv) begin
                        errors++;
                        $display("FAIL %s got clr/en/load=%b rcving=%b expected %b rcving=%b",
                                 e.name, strb, rcving, e.strb, e.rcv);
                    end
                end
            end
            if (snap_req) begin
                checks++;
                if (q.size() == 0 || !q[0].is_status) begin
                    errors++;
                    $display("FAIL snapshot_order got pending strobe or empty queue, expected status entry");
                    if (q.size() != 0) void'(q.pop_front());
                end else begin
                    e = q.pop_front();
                    if (rcving !== e.rcv || data_ready !== e.dr || overrun_error !== e.ov ||
                        framing_error !== e.fe || good_count !== e.gc || err_count !== e.ec) begin
                        errors++;
                        $display("FAIL %s got rcv=%b dr=%b ov=%b fe=%b gc=%0d ec=%0d expected rcv=%b dr=%b ov=%b fe=%b gc=%0d ec=%0d",
                                 e.name, rcving, data_ready, overrun_error, framing_error, good_count, err_count,
                                 e.rcv, e.dr, e.ov, e.fe, e.gc, e.ec);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        snap("reset", 1'b0);
        tick();
        n_rst = 1'b1;
        tick();
        snap("idle_after_reset", 1'b0);

        frame(1'b1, 1'b0, 89, 1'b1);
        read_pulse();
        snap("after_read", 1'b0);

        frame(1'b0, 1'b0, 89, 1'b0);
        repeat (5) tick();
        snap("framing_sticky", 1'b0);
        frame(1'b1, 1'b0, 89, 1'b1);

        frame(1'b1, 1'b0, 40, 1'b0);
        read_pulse();
        snap("overrun_cleared", 1'b0);
        read_pulse();
        snap("read_when_empty", 1'b0);

        frame(1'b1, 1'b0, 20, 1'b0);
        frame(1'b1, 1'b1, 20, 1'b1);
        read_pulse();

        frame(1'b1, 1'b0, 200, 1'b0);
        read_pulse();

        timeout_frame();
        frame(1'b1, 1'b0, 10, 1'b0);

        reset_mid_frame();
        frame(1'b1, 1'b0, 89, 1'b0);

        for (int i = 0; i < 256; i++) begin
            frame(1'b1, 1'b0, 3, 1'b0);
        end
        repeat (2) tick();
        for (int i = 0; i < 254; i++) begin
            frame(1'b0, 1'b0, 2, 1'b0);
        end
        frame(1'b0, 1'b0, 2, 1'b0);

        repeat (3) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending entries expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rcv_sequencer.md
Name: rcv_sequencer

Overview:
- Receive-side controller for the serial receiver. It drives the bit timer's `rcving` input and consumes its `byte_received` flag.
- It validates the stop bit, commands the shift-register buffer load, and owns the `data_ready` / `data_read` handshake with the consumer.
- It owns the framing and overrun error flags and a receive watchdog.
- It sits between the start-bit edge detector, the bit timer, the shift register and the receive buffer.

Parameters:
- TIMEOUT_CYCLES, 200, maximum cycles spent in RECEIVE before the frame is aborted as a framing error.
- CNT_BITS, 8, width of the good-frame and error-frame status counters.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous, active-low reset.
- start_bit_detected  input  1  single-cycle pulse from the edge detector on a falling serial edge.
- byte_received  input  1  from the bit timer; pulses when all data and stop samples have been shifted.
- stop_bit  input  1  stop bit held in the shift register.
- data_read  input  1  consumer acknowledge; single-cycle pulse.
- rcving  output  1  feeds the bit timer `rcving`; high in START and RECEIVE.
- sbc_clear  output  1  clears the stop-bit checker; pulses in START.
- sbc_enable  output  1  stop-bit check strobe; pulses in STOP_CHK.
- load_buffer  output  1  loads the shifted byte into the receive buffer; pulses in LOAD.
- data_ready  output  1  registered; a byte is available.
- overrun_error  output  1  registered; a byte was overwritten before it was read.
- framing_error  output  1  registered; the last frame had a bad stop bit or timed out.
- good_count  output  CNT_BITS  frames loaded, saturating.
- err_count  output  CNT_BITS  frames rejected, saturating.

Behaviour:
- Reset (asynchronous, n_rst=0): state=IDLE; all outputs 0; both counters 0; watchdog 0. Reset mid-frame aborts the frame with no load.
- States: IDLE, START, RECEIVE, STOP_CHK, STOP_WAIT, LOAD, ERR.
- Strobe outputs (sbc_clear, sbc_enable, load_buffer) are Moore-decoded from the state register and are never high in IDLE.
- IDLE:
  - start_bit_detected=1 -> START.
  - framing_error clears on this transition, not before.
- START:
  - One cycle; sbc_clear=1, rcving=1; watchdog cleared.
  - Always -> RECEIVE.
- RECEIVE:
  - rcving=1; watchdog increments every cycle.
  - byte_received=1 -> STOP_CHK. This takes priority over timeout in the same cycle.
  - Watchdog reaches TIMEOUT_CYCLES-1 without byte_received -> ERR.
  - start_bit_detected is ignored while in RECEIVE.
- STOP_CHK:
  - One cycle; sbc_enable=1.
  - Always -> STOP_WAIT.
- STOP_WAIT:
  - One cycle, so the checker's registered result can settle.
  - stop_bit=1 -> LOAD; stop_bit=0 -> ERR.
- LOAD:
  - One cycle; load_buffer=1.
  - Next cycle: data_ready<=1 and good_count increments (saturates at all-ones).
  - If data_ready was already 1 and data_read is not 1 in the LOAD cycle, overrun_error<=1.
  - Always -> IDLE.
- ERR:
  - One cycle; framing_error<=1 and err_count increments (saturating).
  - No load; data_ready is unchanged.
  - Always -> IDLE.
- data_ready:
  - Cleared the cycle after data_read=1.
  - If LOAD and data_read fall in the same cycle, the set wins: data_ready stays 1 and no overrun is flagged.
- overrun_error: sticky; cleared only by a data_read that leaves data_ready at 0.
- data_read while data_ready=0: no effect.
- Timing:
  - Minimum frame latency from the start_bit_detected pulse to load_buffer: 3 cycles plus the byte_received latency (IDLE->START->RECEIVE ... STOP_CHK->STOP_WAIT->LOAD).
  - data_ready asserts 1 cycle after load_buffer.

Decomposition:
- Package `rcv_pkg`:
  - state enum (3-bit encoded).
  - default TIMEOUT_CYCLES and CNT_BITS constants.
  - saturating-increment function.
- Sub-module: the watchdog, built as an instance of the existing `flex_counter`.
  - clear = (state==START).
  - count_enable = (state==RECEIVE).
  - rollover_val = TIMEOUT_CYCLES-1; its rollover_flag is the timeout.
- Everything else is inline.

Test Plan:
- Good frame: start pulse; byte_received 90 cycles later; stop_bit=1 -> sbc_clear, then sbc_enable, then load_buffer exactly once; data_ready=1; good_count=1; no error flags.
- Bad stop: same stimulus with stop_bit=0 -> no load_buffer; framing_error=1; err_count=1. The next start pulse clears framing_error.
- Overrun: two good frames with no data_read -> overrun_error=1 after the second LOAD; a subsequent data_read clears both data_ready and overrun_error.
- LOAD/data_read collision: data_read pulsed in the second frame's LOAD cycle -> data_ready stays 1; overrun_error=0.
- Timeout: start pulse, byte_received never asserted, TIMEOUT_CYCLES=200 -> ERR reached on cycle 200 of RECEIVE; framing_error=1; rcving drops; err_count increments.
- Reset mid-frame: n_rst=0 while in RECEIVE -> all outputs 0 immediately; a later good frame is received normally; counters saturate at 255 after 256 good frames.
